// File: rtl/ex_mem_skid_pkg.sv
// rtl/ex_mem_skid_pkg.sv - shared types and constants for the EX/MEM skid buffer
package ex_mem_skid_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  // Buffer fill level doubles as the FSM state encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // One instruction's worth of execute-stage results and memory-stage control.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] out;
    logic                  zero;
    logic                  ofl;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_W_DEF-1:0]  rd;
    logic                  wr_en;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  halt;
  } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_slot.sv
// rtl/ex_mem_slot.sv - one entry-wide storage register with write enable and clear
module ex_mem_slot
  import ex_mem_skid_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_n,
  input  logic          we_i,
  input  ex_mem_entry_t d_i,
  output ex_mem_entry_t q_o
);

  ex_mem_entry_t entry_q;

  // Clear (reset or flush) takes priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      entry_q <= '0;
    end else if (we_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - two-entry skid buffer between execute and memory stages
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_out,
  input  logic              ex_zero,
  input  logic              ex_ofl,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_wr_en,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_halt,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_zero,
  output logic              mem_ofl,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_wr_en,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic              mem_halt,
  input  logic              flush,
  input  logic              ofl_clr,
  output logic              ofl_sticky,
  output logic              halt_seen,
  output logic [1:0]        occupancy
);

  occ_state_t    state_q, state_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          ready_q, ready_d;
  logic          halt_q, halt_d;
  logic          ofl_q, ofl_d;

  logic          accept;
  logic          release_w;
  logic          we0, we1;
  ex_mem_entry_t in_entry;
  ex_mem_entry_t slot0_q, slot1_q;
  ex_mem_entry_t head;
  ex_mem_entry_t mem_entry;

  assign accept    = ex_valid & ready_q;
  assign mem_valid = (state_q != OCC_EMPTY);
  assign release_w = mem_valid & mem_ready;

  assign in_entry = '{
    out:    ex_out,
    zero:   ex_zero,
    ofl:    ex_ofl,
    wdata:  ex_wdata,
    rd:     ex_rd,
    wr_en:  ex_wr_en,
    mem_rd: ex_mem_rd,
    mem_wr: ex_mem_wr,
    halt:   ex_halt
  };

  // An accept coinciding with flush is dropped, so it must not touch a slot.
  assign we0 = accept & ~flush & (wr_ptr_q == 1'b0);
  assign we1 = accept & ~flush & (wr_ptr_q == 1'b1);

  ex_mem_slot u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (~flush),
    .we_i  (we0),
    .d_i   (in_entry),
    .q_o   (slot0_q)
  );

  ex_mem_slot u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (~flush),
    .we_i  (we1),
    .d_i   (in_entry),
    .q_o   (slot1_q)
  );

  // Occupancy FSM, pointers, halt latch, ready and sticky overflow next-state.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ release_w;
    halt_d   = halt_q | (accept & ex_halt);
    ofl_d    = ofl_q;

    unique case (state_q)
      OCC_EMPTY: if (accept) state_d = OCC_ONE;
      OCC_ONE: begin
        if (accept && !release_w)      state_d = OCC_FULL;
        else if (release_w && !accept) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (release_w) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase

    if (flush) begin
      state_d  = OCC_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      halt_d   = 1'b0;
    end

    // A delivery during flush still counts; set beats clear.
    if (release_w && head.ofl) begin
      ofl_d = 1'b1;
    end else if (ofl_clr) begin
      ofl_d = 1'b0;
    end

    ready_d = (state_d != OCC_FULL) & ~halt_d;
  end

  // State registers; reset overrides flush and any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
      halt_q   <= 1'b0;
      ofl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      halt_q   <= halt_d;
      ofl_q    <= ofl_d;
    end
  end

  assign head      = rd_ptr_q ? slot1_q : slot0_q;
  assign mem_entry = mem_valid ? head : '0;

  assign mem_out    = mem_entry.out;
  assign mem_zero   = mem_entry.zero;
  assign mem_ofl    = mem_entry.ofl;
  assign mem_wdata  = mem_entry.wdata;
  assign mem_rd     = mem_entry.rd;
  assign mem_wr_en  = mem_entry.wr_en;
  assign mem_mem_rd = mem_entry.mem_rd;
  assign mem_mem_wr = mem_entry.mem_wr;
  assign mem_halt   = mem_entry.halt;

  assign ex_ready   = ready_q;
  assign halt_seen  = halt_q;
  assign ofl_sticky = ofl_q;
  assign occupancy  = state_q;

endmodule
